// File: rtl/spec_multi_port_fifo_controller_if.sv
// spec_multi_port_fifo_controller_if: handshake/pointer bundle for the multi-port FIFO controller.
// Revision: 1.0
`default_nettype none

interface spec_multi_port_fifo_controller_if #(
  parameter int DEPTH   = 8,
  parameter int NUM_IN  = 2,
  parameter int NUM_OUT = 2
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(NUM_IN + 1);
  localparam int OW = $clog2(NUM_OUT + 1);

  logic          i_valid;
  logic [IW-1:0] i_num;
  logic          i_ready;
  logic          o_valid;
  logic [OW-1:0] o_avail;
  logic [OW-1:0] o_take;
  logic          o_ready;
  logic [PW-1:0] o_write_ptr;
  logic [PW-1:0] o_read_ptr;
  logic [CW-1:0] o_count;
  logic          i_spec_mark;
  logic          i_branch_valid;
  logic          i_branch_correct_prediction;
  logic          o_spec_active;

  modport slave (
    input  i_valid, i_num, o_take, o_ready,
    input  i_spec_mark, i_branch_valid, i_branch_correct_prediction,
    output i_ready, o_valid, o_avail, o_write_ptr, o_read_ptr, o_count, o_spec_active
  );

  modport master (
    output i_valid, i_num, o_take, o_ready,
    output i_spec_mark, i_branch_valid, i_branch_correct_prediction,
    input  i_ready, o_valid, o_avail, o_write_ptr, o_read_ptr, o_count, o_spec_active
  );
endinterface

`default_nettype wire

// File: rtl/spec_multi_port_fifo_controller.sv
// spec_multi_port_fifo_controller: multi-push/multi-pop queue pointers with one-level speculation flush.
// Revision: 1.0
`default_nettype none

module spec_multi_port_fifo_controller #(
  parameter int DEPTH   = 8,
  parameter int NUM_IN  = 2,
  parameter int NUM_OUT = 2
) (
  input  logic clk,
  input  logic rst,
  spec_multi_port_fifo_controller_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(NUM_OUT + 1);
  localparam int SW = CW + 1;

  localparam logic [CW-1:0] C_READY_MAX = CW'(DEPTH - NUM_IN);
  localparam logic [CW-1:0] C_NUM_OUT   = CW'(NUM_OUT);
  localparam logic [SW-1:0] C_DEPTH_S   = SW'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SPEC = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_head, r_tail, w_head_nxt, w_tail_nxt;
  logic [CW-1:0] r_count, r_nonspec, w_count_nxt, w_nonspec_nxt;

  logic          w_flush, w_ready, w_valid;
  logic [CW-1:0] w_push, w_pop, w_nonspec_left, w_count_upd;

  // Sum is at most 2*DEPTH-1, so one conditional subtract always lands in range.
  function automatic logic [PW-1:0] f_wrap(input logic [PW-1:0] ptr, input logic [CW-1:0] inc);
    logic [SW-1:0] sum;
    sum = SW'(ptr) + SW'(inc);
    if (sum >= C_DEPTH_S) sum = sum - C_DEPTH_S;
    return sum[PW-1:0];
  endfunction

  assign w_valid        = (r_count != '0);
  assign w_flush        = bus.i_branch_valid && !bus.i_branch_correct_prediction && (r_state == S_SPEC);
  assign w_ready        = (r_count <= C_READY_MAX) && !w_flush;
  assign w_push         = (bus.i_valid && w_ready) ? CW'(bus.i_num) : '0;
  assign w_pop          = (w_valid && bus.o_ready) ? CW'(bus.o_take) : '0;
  assign w_nonspec_left = (r_nonspec > w_pop) ? (r_nonspec - w_pop) : '0;
  assign w_count_upd    = r_count + w_push - w_pop;

  always_comb begin
    w_state_nxt   = r_state;
    w_head_nxt    = f_wrap(r_head, w_pop);
    w_tail_nxt    = f_wrap(r_tail, w_push);
    w_count_nxt   = w_count_upd;
    w_nonspec_nxt = (r_state == S_SPEC) ? w_nonspec_left : r_nonspec;

    if (w_flush) begin
      w_count_nxt = w_nonspec_left;
      w_tail_nxt  = f_wrap(r_head, w_pop + w_nonspec_left);
    end

    case (r_state)
      S_IDLE: begin
        if (bus.i_spec_mark) begin
          w_state_nxt   = S_SPEC;
          w_nonspec_nxt = r_count - w_pop;
        end
      end
      S_SPEC: begin
        // A mark alongside resolution reopens a checkpoint covering everything already held.
        if (bus.i_branch_valid) begin
          if (bus.i_spec_mark) w_nonspec_nxt = w_count_nxt;
          else                 w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_nonspec <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_head    <= w_head_nxt;
      r_tail    <= w_tail_nxt;
      r_count   <= w_count_nxt;
      r_nonspec <= w_nonspec_nxt;
    end
  end

  assign bus.i_ready       = w_ready;
  assign bus.o_valid       = w_valid;
  assign bus.o_avail       = (r_count >= C_NUM_OUT) ? OW'(NUM_OUT) : OW'(r_count);
  assign bus.o_write_ptr   = r_tail;
  assign bus.o_read_ptr    = r_head;
  assign bus.o_count       = r_count;
  assign bus.o_spec_active = (r_state == S_SPEC);

endmodule

`default_nettype wire

// File: tb/tb_spec_multi_port_fifo_controller.sv
// tb_spec_multi_port_fifo_controller: directed self-checking bench for the speculative multi-port FIFO controller.
// Revision: 1.0
`default_nettype none

module tb_spec_multi_port_fifo_controller;
  localparam int DEPTH   = 8;
  localparam int NUM_IN  = 2;
  localparam int NUM_OUT = 2;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  spec_multi_port_fifo_controller_if #(.DEPTH(DEPTH), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT)) bus ();

  spec_multi_port_fifo_controller #(.DEPTH(DEPTH), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.i_valid) assert (bus.i_num <= 2'(NUM_IN)) else $error("illegal i_num %0d", bus.i_num);
      if (bus.o_valid && bus.o_ready) assert (bus.o_take <= bus.o_avail) else $error("illegal o_take %0d", bus.o_take);
    end
  end

  task automatic drive(input logic v, input logic [1:0] num, input logic rdy, input logic [1:0] take,
                       input logic mark, input logic bv, input logic bc);
    bus.i_valid                     = v;
    bus.i_num                       = num;
    bus.o_ready                     = rdy;
    bus.o_take                      = take;
    bus.i_spec_mark                 = mark;
    bus.i_branch_valid              = bv;
    bus.i_branch_correct_prediction = bc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", bus.o_valid); end
    n_cmp++; if (bus.o_avail !== 2'd0) begin n_err++; $display("FAIL reset_avail got %0d want 0", bus.o_avail); end
    n_cmp++; if (bus.o_count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus.o_count); end
    n_cmp++; if (bus.o_write_ptr !== 3'd0 || bus.o_read_ptr !== 3'd0) begin n_err++; $display("FAIL reset_ptrs got wp=%0d rp=%0d want 0/0", bus.o_write_ptr, bus.o_read_ptr); end
    n_cmp++; if (bus.o_spec_active !== 1'b0) begin n_err++; $display("FAIL reset_spec got %0b want 0", bus.o_spec_active); end
    n_cmp++; if (bus.i_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", bus.i_ready); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 2, 0, 0, 0, 0, 0);
      #1;
      n_cmp++; if (bus.o_write_ptr !== 3'(2 * i)) begin n_err++; $display("FAIL fill_wp[%0d] got %0d want %0d", i, bus.o_write_ptr, 2 * i); end
      n_cmp++; if (bus.i_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready[%0d] got %0b want 1", i, bus.i_ready); end
      tick();
      n_cmp++; if (bus.o_count !== 4'(2 * (i + 1))) begin n_err++; $display("FAIL fill_count[%0d] got %0d want %0d", i, bus.o_count, 2 * (i + 1)); end
    end
    drive(1, 1, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (bus.i_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready6 got %0b want 1", bus.i_ready); end
    tick();
    n_cmp++; if (bus.o_count !== 4'd7) begin n_err++; $display("FAIL fill_count7 got %0d want 7", bus.o_count); end
    drive(1, 2, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (bus.i_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready7 got %0b want 0", bus.i_ready); end
    tick();
    n_cmp++; if (bus.o_count !== 4'd7 || bus.o_write_ptr !== 3'd7) begin n_err++; $display("FAIL fill_reject got count=%0d wp=%0d want 7/7", bus.o_count, bus.o_write_ptr); end
    n_cmp++; if (bus.o_avail !== 2'd2 || bus.o_valid !== 1'b1) begin n_err++; $display("FAIL fill_avail got avail=%0d valid=%0b want 2/1", bus.o_avail, bus.o_valid); end
  endtask

  task automatic test_wrap();
    logic [2:0] exp_wp [2];
    logic [2:0] exp_rp [2];
    exp_wp = '{3'd0, 3'd2};
    exp_rp = '{3'd6, 3'd0};
    do_reset();
    for (int i = 0; i < 3; i++) begin drive(1, 2, 0, 0, 0, 0, 0); tick(); end
    for (int i = 0; i < 3; i++) begin drive(0, 0, 1, 2, 0, 0, 0); tick(); end
    n_cmp++; if (bus.o_read_ptr !== 3'd6 || bus.o_write_ptr !== 3'd6 || bus.o_count !== 4'd0) begin n_err++; $display("FAIL wrap_start got rp=%0d wp=%0d count=%0d want 6/6/0", bus.o_read_ptr, bus.o_write_ptr, bus.o_count); end
    drive(1, 2, 1, 2, 0, 0, 0);
    #1;
    n_cmp++; if (bus.o_write_ptr !== 3'd6 || bus.o_valid !== 1'b0) begin n_err++; $display("FAIL wrap_first got wp=%0d valid=%0b want 6/0", bus.o_write_ptr, bus.o_valid); end
    tick();
    n_cmp++; if (bus.o_count !== 4'd2) begin n_err++; $display("FAIL wrap_empty_pop got count=%0d want 2", bus.o_count); end
    for (int i = 0; i < 2; i++) begin
      drive(1, 2, 1, 2, 0, 0, 0);
      #1;
      n_cmp++; if (bus.o_write_ptr !== exp_wp[i] || bus.o_read_ptr !== exp_rp[i]) begin n_err++; $display("FAIL wrap_ptr[%0d] got wp=%0d rp=%0d want %0d/%0d", i, bus.o_write_ptr, bus.o_read_ptr, exp_wp[i], exp_rp[i]); end
      tick();
      n_cmp++; if (bus.o_count !== 4'd2) begin n_err++; $display("FAIL wrap_count[%0d] got %0d want 2", i, bus.o_count); end
    end
    n_cmp++; if (bus.o_write_ptr !== 3'd4 || bus.o_read_ptr !== 3'd2) begin n_err++; $display("FAIL wrap_end got wp=%0d rp=%0d want 4/2", bus.o_write_ptr, bus.o_read_ptr); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 2, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0, 0); tick();
    drive(1, 2, 0, 0, 1, 0, 0); tick();
    n_cmp++; if (bus.o_count !== 4'd5 || bus.o_spec_active !== 1'b1 || bus.o_write_ptr !== 3'd5) begin n_err++; $display("FAIL flush_mark got count=%0d spec=%0b wp=%0d want 5/1/5", bus.o_count, bus.o_spec_active, bus.o_write_ptr); end
    drive(0, 0, 1, 2, 0, 0, 0); tick();
    n_cmp++; if (bus.o_count !== 4'd3 || bus.o_read_ptr !== 3'd2) begin n_err++; $display("FAIL flush_pop got count=%0d rp=%0d want 3/2", bus.o_count, bus.o_read_ptr); end
    drive(1, 2, 1, 1, 0, 1, 0);
    #1;
    n_cmp++; if (bus.i_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got %0b want 0", bus.i_ready); end
    tick();
    n_cmp++; if (bus.o_count !== 4'd0 || bus.o_valid !== 1'b0) begin n_err++; $display("FAIL flush_count got count=%0d valid=%0b want 0/0", bus.o_count, bus.o_valid); end
    n_cmp++; if (bus.o_read_ptr !== 3'd3 || bus.o_write_ptr !== 3'd3) begin n_err++; $display("FAIL flush_ptrs got rp=%0d wp=%0d want 3/3", bus.o_read_ptr, bus.o_write_ptr); end
    n_cmp++; if (bus.o_spec_active !== 1'b0) begin n_err++; $display("FAIL flush_spec got %0b want 0", bus.o_spec_active); end
  endtask

  task automatic test_correct();
    do_reset();
    drive(1, 2, 0, 0, 0, 0, 0); tick();
    drive(1, 2, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0, 0); tick();
    n_cmp++; if (bus.o_spec_active !== 1'b1) begin n_err++; $display("FAIL correct_mark got %0b want 1", bus.o_spec_active); end
    drive(1, 2, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 1); tick();
    n_cmp++; if (bus.o_count !== 4'd6 || bus.o_spec_active !== 1'b0) begin n_err++; $display("FAIL correct_resolve got count=%0d spec=%0b want 6/0", bus.o_count, bus.o_spec_active); end
    drive(0, 0, 0, 0, 0, 1, 0);
    #1;
    n_cmp++; if (bus.i_ready !== 1'b1) begin n_err++; $display("FAIL correct_idle_ready got %0b want 1", bus.i_ready); end
    tick();
    n_cmp++; if (bus.o_count !== 4'd6 || bus.o_write_ptr !== 3'd6) begin n_err++; $display("FAIL correct_ignored got count=%0d wp=%0d want 6/6", bus.o_count, bus.o_write_ptr); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive(1, 2, 0, 0, 0, 0, 0); tick();
    drive(1, 2, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0, 0); tick();
    drive(1, 2, 0, 0, 0, 0, 0); tick();
    drive(1, 2, 0, 0, 1, 1, 0);
    #1;
    n_cmp++; if (bus.i_ready !== 1'b0) begin n_err++; $display("FAIL simul_ready got %0b want 0", bus.i_ready); end
    tick();
    n_cmp++; if (bus.o_count !== 4'd4 || bus.o_write_ptr !== 3'd4 || bus.o_spec_active !== 1'b1) begin n_err++; $display("FAIL simul_flush got count=%0d wp=%0d spec=%0b want 4/4/1", bus.o_count, bus.o_write_ptr, bus.o_spec_active); end
    drive(1, 2, 0, 0, 0, 0, 0); tick();
    n_cmp++; if (bus.o_count !== 4'd6) begin n_err++; $display("FAIL simul_push got count=%0d want 6", bus.o_count); end
    drive(0, 0, 0, 0, 0, 1, 0); tick();
    n_cmp++; if (bus.o_count !== 4'd4 || bus.o_write_ptr !== 3'd4 || bus.o_spec_active !== 1'b0) begin n_err++; $display("FAIL simul_reflush got count=%0d wp=%0d spec=%0b want 4/4/0", bus.o_count, bus.o_write_ptr, bus.o_spec_active); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1, 2, 0, 0, 0, 0, 0); tick();
    drive(1, 2, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 1, 0, 0); tick();
    n_cmp++; if (bus.o_count !== 4'd5 || bus.o_spec_active !== 1'b1) begin n_err++; $display("FAIL async_pre got count=%0d spec=%0b want 5/1", bus.o_count, bus.o_spec_active); end
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.o_count !== 4'd0 || bus.o_valid !== 1'b0 || bus.o_avail !== 2'd0) begin n_err++; $display("FAIL async_count got count=%0d valid=%0b avail=%0d want 0/0/0", bus.o_count, bus.o_valid, bus.o_avail); end
    n_cmp++; if (bus.o_spec_active !== 1'b0 || bus.i_ready !== 1'b1) begin n_err++; $display("FAIL async_spec got spec=%0b ready=%0b want 0/1", bus.o_spec_active, bus.i_ready); end
    n_cmp++; if (bus.o_write_ptr !== 3'd0 || bus.o_read_ptr !== 3'd0) begin n_err++; $display("FAIL async_ptrs got wp=%0d rp=%0d want 0/0", bus.o_write_ptr, bus.o_read_ptr); end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_fill();
    test_wrap();
    test_flush();
    test_correct();
    test_simultaneous();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
